// File: rtl/mu0_bus_io_bridge_if.sv
// CPU-side, RAM-side and TX-stream signals of the MU0 bus/I-O bridge.
// The bridge takes the slave modport. The CPU, RAM and consumer side takes the master modport.
interface mu0_bus_io_bridge_if;
   logic [11:0] cpu_address;
   logic        cpu_write;
   logic        cpu_read;
   logic [15:0] cpu_writedata;
   logic [15:0] cpu_readdata;
   logic [11:0] ram_address;
   logic        ram_write;
   logic        ram_read;
   logic [15:0] ram_writedata;
   logic [15:0] ram_readdata;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport slave (
      input  cpu_address, cpu_write, cpu_read, cpu_writedata, ram_readdata, out_ready,
      output cpu_readdata, ram_address, ram_write, ram_read, ram_writedata, out_data, out_valid
   );

   modport master (
      output cpu_address, cpu_write, cpu_read, cpu_writedata, ram_readdata, out_ready,
      input  cpu_readdata, ram_address, ram_write, ram_read, ram_writedata, out_data, out_valid
   );
endinterface

// File: rtl/mu0_bus_io_bridge.sv
// MU0 bus bridge: passes RAM accesses through and decodes the top three words as I/O registers.
// The I/O registers are TX_DATA, STATUS and CYCLES. A TX FIFO feeds a valid/ready output stream.
module mu0_bus_io_bridge #(
   parameter int FIFO_DEPTH = 8
) (
   input logic               clk,
   input logic               rst,
   mu0_bus_io_bridge_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [11:0] ADDR_TX     = 12'hFFF;
   localparam logic [11:0] ADDR_STATUS = 12'hFFE;
   localparam logic [11:0] ADDR_CYCLES = 12'hFFD;

   logic [15:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             overflow;
   logic [15:0]      cycles;

   logic is_io, empty, full, pop, tx_write, push, drop, status_clr;

   assign is_io      = (bus.cpu_address >= ADDR_CYCLES);
   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign pop        = !empty && bus.out_ready;
   assign tx_write   = bus.cpu_write && (bus.cpu_address == ADDR_TX);
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign push       = tx_write && (!full || pop);
   assign drop       = tx_write && !push;
   assign status_clr = bus.cpu_write && (bus.cpu_address == ADDR_STATUS) && bus.cpu_writedata[15];

   // The RAM never sees an I/O access. The paths stay live even during reset.
   assign bus.ram_address   = bus.cpu_address;
   assign bus.ram_writedata = bus.cpu_writedata;
   assign bus.ram_write     = bus.cpu_write && !is_io;
   assign bus.ram_read      = bus.cpu_read && !is_io;

   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? 16'h0000 : mem[rd_ptr];

   always_comb begin
      // NOTE: default first so every path assigns the signal and no latch is inferred.
      bus.cpu_readdata = bus.ram_readdata;
      if (is_io) begin
         case (bus.cpu_address)
            ADDR_STATUS: bus.cpu_readdata = {overflow, empty, full, 8'b0, 5'(count)};
            ADDR_CYCLES: bus.cpu_readdata = cycles;
            default:     bus.cpu_readdata = 16'h0000;
         endcase
      end
   end

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         cycles   <= '0;
      end else begin
         cycles <= cycles + 16'd1;
         count  <= count_next;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         // A drop on the same edge as a clear keeps the flag set.
         if (drop)            overflow <= 1'b1;
         else if (status_clr) overflow <= 1'b0;
      end
   end

   // NOTE: the storage array has no reset. Emptiness comes from count, so stale words are never visible.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= bus.cpu_writedata;
   end
endmodule

// File: tb/tb_mu0_bus_io_bridge.sv
// Directed self-checking bench for mu0_bus_io_bridge.
// A small behavioural RAM stands in for the memory.
module tb_mu0_bus_io_bridge;
   localparam logic [11:0] A_TX     = 12'hFFF;
   localparam logic [11:0] A_STATUS = 12'hFFE;
   localparam logic [11:0] A_CYCLES = 12'hFFD;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] ram_model [4096];

   mu0_bus_io_bridge_if bus ();

   mu0_bus_io_bridge #(.FIFO_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.ram_readdata = ram_model[bus.ram_address];
   always @(posedge clk) if (bus.ram_write) ram_model[bus.ram_address] <= bus.ram_writedata;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.cpu_write     = 1'b0;
      bus.cpu_read      = 1'b0;
      bus.cpu_address   = 12'h000;
      bus.cpu_writedata = 16'h0000;
   endtask

   task automatic cpu_wr(input logic [11:0] addr, input logic [15:0] data);
      bus.cpu_address   = addr;
      bus.cpu_writedata = data;
      bus.cpu_write     = 1'b1;
      tick();
      idle();
   endtask

   task automatic cpu_rd(input string tag, input logic [11:0] addr, input logic [15:0] exp);
      bus.cpu_address = addr;
      bus.cpu_read    = 1'b1;
      #1;
      check(tag, bus.cpu_readdata, exp);
      idle();
   endtask

   initial begin
      idle();
      bus.out_ready = 1'b0;

      // Reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_cycles", {8'h00, 8'h00} | 16'(bus.out_valid), 16'h0000);
      check("rst_out_data", bus.out_data, 16'h0000);
      cpu_rd("rst_status", A_STATUS, 16'h4000);
      cpu_rd("rst_cycles_rd", A_CYCLES, 16'h0000);

      // Single push with 1-cycle latency, held while not ready
      bus.cpu_address = A_TX; bus.cpu_writedata = 16'h1234; bus.cpu_write = 1'b1; bus.cpu_read = 1'b1;
      #1;
      check("io_ram_write", 16'(bus.ram_write), 16'h0000);
      check("io_ram_read", 16'(bus.ram_read), 16'h0000);
      check("tx_read_zero", bus.cpu_readdata, 16'h0000);
      tick();
      idle();
      check("push_valid", 16'(bus.out_valid), 16'h0001);
      check("push_data", bus.out_data, 16'h1234);
      cpu_rd("push_status", A_STATUS, 16'h0001);
      tick();
      check("hold_data", bus.out_data, 16'h1234);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pop_empty_valid", 16'(bus.out_valid), 16'h0000);
      check("pop_empty_data", bus.out_data, 16'h0000);

      // Overflow: nine writes into depth 8, then drain
      for (int i = 1; i <= 9; i++) cpu_wr(A_TX, 16'(i));
      cpu_rd("ovf_status", A_STATUS, 16'hA008);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_%0d", i), bus.out_data, 16'(i));
         tick();
      end
      bus.out_ready = 1'b0;
      check("drained_valid", 16'(bus.out_valid), 16'h0000);
      cpu_rd("drained_status", A_STATUS, 16'hC000);

      // STATUS write without bit15 is ignored. A combined read+write sees the pre-edge value.
      cpu_wr(A_STATUS, 16'h7FFF);
      cpu_rd("clr_ignored", A_STATUS, 16'hC000);
      bus.cpu_address = A_STATUS; bus.cpu_writedata = 16'h8000; bus.cpu_write = 1'b1; bus.cpu_read = 1'b1;
      #1;
      check("rw_pre_edge", bus.cpu_readdata, 16'hC000);
      tick();
      idle();
      cpu_rd("clr_status", A_STATUS, 16'h4000);

      // Full FIFO with a same-edge pop accepts 0x00AA
      for (int i = 0; i < 8; i++) cpu_wr(A_TX, 16'h0010 + 16'(i));
      cpu_rd("full_status", A_STATUS, 16'h2008);
      bus.out_ready = 1'b1;
      cpu_wr(A_TX, 16'h00AA);
      bus.out_ready = 1'b0;
      cpu_rd("full_swap_status", A_STATUS, 16'h2008);
      bus.out_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         check($sformatf("swap_drain_%0d", i), bus.out_data, 16'h0010 + 16'(i));
         tick();
      end
      check("swap_last", bus.out_data, 16'h00AA);
      tick();
      bus.out_ready = 1'b0;
      check("swap_empty", 16'(bus.out_valid), 16'h0000);

      // Push and pop on the same edge with count=1
      cpu_wr(A_TX, 16'h0A01);
      bus.out_ready = 1'b1;
      cpu_wr(A_TX, 16'h0A02);
      bus.out_ready = 1'b0;
      check("pp_count1_data", bus.out_data, 16'h0A02);
      cpu_rd("pp_count1_status", A_STATUS, 16'h0001);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // RAM pass-through, including the top RAM word
      bus.cpu_address = 12'h010; bus.cpu_writedata = 16'hBEEF; bus.cpu_write = 1'b1;
      #1;
      check("ram_we", 16'(bus.ram_write), 16'h0001);
      check("ram_addr", 16'(bus.ram_address), 16'h0010);
      check("ram_wdata", bus.ram_writedata, 16'hBEEF);
      tick();
      idle();
      bus.cpu_read = 1'b1; bus.cpu_address = 12'h010;
      #1;
      check("ram_re", 16'(bus.ram_read), 16'h0001);
      idle();
      cpu_rd("ram_rd", 12'h010, 16'hBEEF);
      cpu_wr(12'hFFC, 16'h5A5A);
      cpu_rd("ram_top_rd", 12'hFFC, 16'h5A5A);
      bus.cpu_address = A_CYCLES; bus.cpu_write = 1'b1;
      #1;
      check("cycles_no_ram_we", 16'(bus.ram_write), 16'h0000);
      idle();

      // Reset mid-drain at count=5 overrides a same-cycle push and pop
      for (int i = 0; i < 7; i++) cpu_wr(A_TX, 16'h0100 + 16'(i));
      bus.out_ready = 1'b1;
      tick();
      tick();
      cpu_rd("mid_status", A_STATUS, 16'h0005);
      rst = 1'b1;
      bus.cpu_address = A_TX; bus.cpu_writedata = 16'hDEAD; bus.cpu_write = 1'b1;
      tick();
      bus.cpu_address = 12'h020; bus.cpu_writedata = 16'h1111;
      #1;
      check("rst_ram_we", 16'(bus.ram_write), 16'h0001);
      tick();
      rst = 1'b0;
      idle();
      bus.out_ready = 1'b0;
      check("rst2_valid", 16'(bus.out_valid), 16'h0000);
      cpu_rd("rst2_status", A_STATUS, 16'h4000);
      cpu_rd("rst2_cycles", A_CYCLES, 16'h0000);
      cpu_rd("rst_ram_kept", 12'h020, 16'h1111);

      // CYCLES counts edges since reset and wraps after 65536 cycles
      for (int i = 0; i < 5; i++) tick();
      cpu_rd("cycles_5", A_CYCLES, 16'h0005);
      cpu_wr(A_CYCLES, 16'hFFFF);
      cpu_rd("cycles_wr_ignored", A_CYCLES, 16'h0006);
      for (int i = 0; i < 65536; i++) tick();
      cpu_rd("cycles_wrap", A_CYCLES, 16'h0006);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
